// File: rtl/i2s_rx_sequencer.sv
// i2s_rx_sequencer
//   Receive-side sequencer for an I2S link. Synchronizes the asynchronous
//   bclk/lrclk/data pins into the clk domain, detects bclk rising edges, and
//   produces per-bit shift strobes and per-word load strobes for an external
//   shift register. Words longer than DATA_BITS are truncated, keeping the MSBs.
//   A word shorter than DATA_BITS raises a one-clk frame_error instead of a load.
//
//   Optional feature: define I2S_RX_WATCHDOG_EN to drop lock after
//   TIMEOUT_CYCLES clk cycles without a bclk rise. Without the macro, RUN is
//   left only through reset.
//
// Ports
//   clk                   system clock, all logic on its rising edge
//   reset_n               synchronous active-low reset
//   i2s_bclk/lrclk/data   asynchronous I2S pins
//   i2s_lrclk_s           lrclk captured at each bclk rise
//   i2s_data_s            data bit captured at each bclk rise
//   i2s_data_shift_strobe one-clk pulse: i2s_data_s is valid for shifting
//   i2s_data_load_strobe  one-clk pulse: the shifted word is complete
//   locked                high while in RUN
//   frame_error           one-clk pulse on a short word
//   bit_count             bits received in the current word, saturating at 63
module i2s_rx_sequencer #(
    parameter int unsigned DATA_BITS      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i2s_bclk,
    input  logic       i2s_lrclk,
    input  logic       i2s_data,
    output logic       i2s_lrclk_s,
    output logic       i2s_data_s,
    output logic       i2s_data_shift_strobe,
    output logic       i2s_data_load_strobe,
    output logic       locked,
    output logic       frame_error,
    output logic [5:0] bit_count
);

    if (DATA_BITS < 1 || DATA_BITS > 32 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_param_check
        $error("i2s_rx_sequencer: parameter out of range");
    end

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [6:0] DB = 7'(DATA_BITS);

    state_t     state, state_next;
    logic       bclk_s1, bclk_s2, bclk_s3;
    logic       lr_s1, lr_s2;
    logic       dat_s1, dat_s2;
    logic       edge_e;
    logic       lr_change;
    logic       load_pend, err_pend;
    logic [6:0] word_len;
    logic       timeout;

    assign edge_e    = bclk_s2 & ~bclk_s3;
    // i2s_lrclk_s still holds the lrclk seen at the previous bclk rise here.
    assign lr_change = edge_e & (lr_s2 != i2s_lrclk_s);
    // The bit sampled at the change edge is the LSB of the ending word.
    assign word_len  = {1'b0, bit_count} + 7'd1;
    assign locked    = (state == RUN);

`ifdef I2S_RX_WATCHDOG_EN
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (state != RUN || edge_e || timeout) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 10'd1;
        end
    end

    // Fires on the cycle the count of edge-free cycles reaches TIMEOUT_CYCLES.
    assign timeout = (state == RUN) && !edge_e && (wd_cnt == WD_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SYNC:    if (lr_change) state_next = RUN;
            RUN:     if (timeout)   state_next = SYNC;
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bclk_s1               <= 1'b0;
            bclk_s2               <= 1'b0;
            bclk_s3               <= 1'b0;
            lr_s1                 <= 1'b0;
            lr_s2                 <= 1'b0;
            dat_s1                <= 1'b0;
            dat_s2                <= 1'b0;
            i2s_lrclk_s           <= 1'b0;
            i2s_data_s            <= 1'b0;
            i2s_data_shift_strobe <= 1'b0;
            i2s_data_load_strobe  <= 1'b0;
            frame_error           <= 1'b0;
            load_pend             <= 1'b0;
            err_pend              <= 1'b0;
            bit_count             <= '0;
        end else begin
            bclk_s1 <= i2s_bclk;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            lr_s1   <= i2s_lrclk;
            lr_s2   <= lr_s1;
            dat_s1  <= i2s_data;
            dat_s2  <= dat_s1;

            if (edge_e) begin
                i2s_data_s  <= dat_s2;
                i2s_lrclk_s <= lr_s2;
            end

            // E+1 strobe; bits past DATA_BITS are dropped.
            i2s_data_shift_strobe <= edge_e && (state == RUN) && (state_next == RUN)
                                     && ({1'b0, bit_count} < DB);

            // Word verdict is taken at the change edge and delivered one clk
            // later, so the load always trails the shift of the LSB.
            load_pend <= lr_change && (state == RUN) && (word_len >= DB);
            err_pend  <= lr_change && (state == RUN) && (word_len <  DB);
            i2s_data_load_strobe <= load_pend && (state_next == RUN);
            frame_error          <= err_pend  && (state_next == RUN);

            if (timeout) begin
                bit_count <= '0;
            end else if (edge_e) begin
                if (lr_change) begin
                    bit_count <= '0;
                end else if (bit_count != 6'd63) begin
                    bit_count <= bit_count + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_sequencer.sv
module tb_i2s_rx_sequencer;

`ifdef I2S_RX_WATCHDOG_EN
    localparam int unsigned TO = 20;
`else
    localparam int unsigned TO = 255;
`endif

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       bclk    = 1'b0;
    logic       lrclk   = 1'b0;
    logic       data    = 1'b0;
    logic       lrclk_s, data_s, shift, load, locked, fe;
    logic [5:0] bit_count;

    i2s_rx_sequencer #(
        .DATA_BITS      (16),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .i2s_bclk              (bclk),
        .i2s_lrclk             (lrclk),
        .i2s_data              (data),
        .i2s_lrclk_s           (lrclk_s),
        .i2s_data_s            (data_s),
        .i2s_data_shift_strobe (shift),
        .i2s_data_load_strobe  (load),
        .locked                (locked),
        .frame_error           (fe),
        .bit_count             (bit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        int          nsh;
        bit          adj;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          nsh   = 0;
    int          fe_cnt = 0;
    int          last_shift_cyc = -100;
    int          fall_cyc = -1;
    logic        locked_prev = 1'b0;
    logic        fe_prev = 1'b0;
    logic        load_prev = 1'b0;
    logic [31:0] sr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] w, input int n, input bit adj);
        exp_t e;
        e.w = w; e.nsh = n; e.adj = adj;
        q.push_back(e);
    endtask

    // Called at a negedge; one bclk period is 8 clk (4 low, 4 high).
    task automatic send_bit(input logic lr, input logic d, input bit lockchk);
        bclk = 1'b0; lrclk = lr; data = d;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        if (lockchk) begin
            @(negedge clk);
            @(negedge clk);
            chk("locked_before_e1", {31'b0, locked}, 32'd0);
            @(negedge clk);
            chk("locked_at_e1", {31'b0, locked}, 32'd1);
            chk("bit_count_at_lock", {26'b0, bit_count}, 32'd0);
            @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    // lrclk flips together with the LSB: one-bit I2S delay.
    task automatic send_word(input logic ch, input logic [31:0] w, input int len, input bit lockchk);
        for (int i = len - 1; i >= 1; i--) send_bit(ch, w[i], 1'b0);
        send_bit(~ch, w[0], lockchk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset_n) nsh = 0;
        if (shift) begin
            chk("shift_load_exclusive", {31'b0, load}, 32'd0);
            sr = {sr[30:0], data_s};
            nsh++;
            last_shift_cyc = cyc;
        end
        if (load) begin
            chk("load_width", {31'b0, load_prev}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_load", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("word", {16'b0, sr[15:0]}, {16'b0, e.w});
                chk("shift_count", nsh, e.nsh);
                if (e.adj) chk("load_after_shift", cyc - last_shift_cyc, 32'd1);
            end
            nsh = 0;
        end
        if (fe) begin
            chk("fe_width", {31'b0, fe_prev}, 32'd0);
            fe_cnt++;
            nsh = 0;
        end
        if (locked_prev && !locked && fall_cyc < 0) fall_cyc = cyc;
        locked_prev = locked;
        fe_prev     = fe;
        load_prev   = load;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int delta;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_locked",    {31'b0, locked},    32'd0);
        chk("rst_bit_count", {26'b0, bit_count}, 32'd0);
        chk("rst_shift",     {31'b0, shift},     32'd0);
        chk("rst_load",      {31'b0, load},      32'd0);
        chk("rst_fe",        {31'b0, fe},        32'd0);
        chk("rst_lrclk_s",   {31'b0, lrclk_s},   32'd0);
        chk("rst_data_s",    {31'b0, data_s},    32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Lock: partial word, no load.
        send_word(1'b0, 32'h5A5A, 16, 1'b1);
        repeat (3) @(negedge clk);
        chk("no_load_on_lock", q.size(), 32'd0);

        push(16'h0F0F, 16, 1'b1); send_word(1'b1, 32'h0F0F, 16, 1'b0);
        push(16'h8001, 16, 1'b1); send_word(1'b0, 32'h8001, 16, 1'b0);
        push(16'h7FFE, 16, 1'b1); send_word(1'b1, 32'h7FFE, 16, 1'b0);
        repeat (3) @(negedge clk);
        chk("q_empty_16bit", q.size(), 32'd0);

        push(16'h1234, 16, 1'b0); send_word(1'b0, 32'h1234ABCD, 32, 1'b0);
        repeat (3) @(negedge clk);
        chk("q_empty_32bit", q.size(), 32'd0);
        chk("no_fe_32bit", fe_cnt, 32'd0);

        send_word(1'b1, 32'h00A5, 8, 1'b0);
        repeat (3) @(negedge clk);
        chk("fe_short_word", fe_cnt, 32'd1);
        chk("locked_after_fe", {31'b0, locked}, 32'd1);
        push(16'hC3C3, 16, 1'b1); send_word(1'b0, 32'hC3C3, 16, 1'b0);
        repeat (3) @(negedge clk);
        chk("q_empty_after_fe", q.size(), 32'd0);
        chk("fe_once", fe_cnt, 32'd1);

        // bclk stopped.
        repeat (40) @(negedge clk);
`ifdef I2S_RX_WATCHDOG_EN
        chk("wd_unlocked", {31'b0, locked}, 32'd0);
        chk("wd_bit_count", {26'b0, bit_count}, 32'd0);
        delta = fall_cyc - (last_shift_cyc - 1);
        chk("wd_fall_delay_20_21", {31'b0, (delta >= 20 && delta <= 21)}, 32'd1);
        send_word(1'b1, 32'hFFFF, 16, 1'b0);
        repeat (3) @(negedge clk);
        chk("wd_relocked", {31'b0, locked}, 32'd1);
        chk("no_load_on_relock", q.size(), 32'd0);
        push(16'h1357, 16, 1'b1); send_word(1'b0, 32'h1357, 16, 1'b0);
`else
        delta = fall_cyc;
        chk("no_wd_still_locked", {31'b0, locked}, 32'd1);
        chk("no_wd_never_fell", delta, -1);
`endif
        push(16'h2468, 16, 1'b1); send_word(1'b1, 32'h2468, 16, 1'b0);
        repeat (3) @(negedge clk);
        chk("q_empty_pre_reset", q.size(), 32'd0);
        chk("fe_total_pre_reset", fe_cnt, 32'd1);

        // Mid-word reset, pulsed in the cycle a shift strobe is being raised.
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1'b0);
        bclk = 1'b0; lrclk = 1'b0; data = 1'b1;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mrst_shift",     {31'b0, shift},     32'd0);
        chk("mrst_load",      {31'b0, load},      32'd0);
        chk("mrst_fe",        {31'b0, fe},        32'd0);
        chk("mrst_locked",    {31'b0, locked},    32'd0);
        chk("mrst_bit_count", {26'b0, bit_count}, 32'd0);
        chk("mrst_lrclk_s",   {31'b0, lrclk_s},   32'd0);
        chk("mrst_data_s",    {31'b0, data_s},    32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_shift",  {31'b0, shift},  32'd0);
            chk("post_rst_load",   {31'b0, load},   32'd0);
            chk("post_rst_locked", {31'b0, locked}, 32'd0);
        end
        bclk = 1'b0;
        @(negedge clk);

        send_word(1'b0, 32'h1111, 16, 1'b1);
        push(16'h9ABC, 16, 1'b1); send_word(1'b1, 32'h9ABC, 16, 1'b0);
        repeat (5) @(negedge clk);
        chk("q_empty_final", q.size(), 32'd0);
        chk("fe_total_final", fe_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
